regfile_sb: RTL
===============

# regfile_sb

Parametrised general-purpose register file for the CPU datapath: two read ports and one write port, with a hardwired zero register, same-cycle write-to-read bypass and a per-register pending-write scoreboard. The scoreboard flags read-after-write hazards to the decode/hazard unit. A valid/ready dump port streams every register out, one register per accepted beat, for debug and UART inspection. It sits between decode (read and issue side) and writeback (write side).

## Interface
- XLEN, 32, data width in bits
- NREGS, 32, number of registers; power of two, at least 2
- AW, $clog2(NREGS), register index width
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset; synchronous and active-low (0 resets on a rising clk edge)
- rs1  in  AW  read port 1 index
- rs2  in  AW  read port 2 index
- rd1  out  XLEN  read port 1 data (combinational)
- rd2  out  XLEN  read port 2 data (combinational)
- we  in  1  write enable
- wa  in  AW  write index
- wd  in  XLEN  write data
- iss_valid  in  1  an instruction writing iss_rd issues this cycle
- iss_rd  in  AW  destination index of the issuing instruction
- hazard  out  1  rs1 or rs2 has an unresolved pending write (combinational)
- dump_start  in  1  start a full-file dump
- dump_ready  in  1  consumer accepts the current dump beat
- dump_valid  out  1  dump beat valid
- dump_idx  out  AW  index of the current beat
- dump_data  out  XLEN  contents of regs[dump_idx]
- dump_busy  out  1  dump in progress

## Operation
- Register 0 always reads as 0. Writes to index 0 are discarded. pend[0] never sets.
- Write: if we=1 and wa!=0, then regs[wa] <= wd.
- Read with bypass:
  - rdN = 0 when rsN=0.
  - Otherwise rdN = wd when we=1 and wa=rsN.
  - Otherwise rdN = regs[rsN].
- Scoreboard pend[NREGS-1:0]:
  - Set: pend[iss_rd] is set when iss_valid=1 and iss_rd!=0.
  - Clear: pend[wa] is cleared when we=1 and wa!=0.
  - Set and clear on the same index in the same cycle: set wins, because the new producer supersedes the old one.
  - Set and clear on different indices in the same cycle are independent.
- hazard = h1 | h2, where hN = (rsN!=0) & pend[rsN] & ~(we & (wa==rsN)).
  - A write in flight this cycle resolves the hazard through the bypass.
- Dump FSM with states IDLE and SCAN:
  - IDLE: dump_valid=0 and dump_busy=0. dump_start=1 moves to SCAN with dump_idx=0.
  - SCAN: dump_valid=1, dump_busy=1, dump_data = regs[dump_idx] (raw array value, no bypass).
  - On dump_valid & dump_ready: if dump_idx=NREGS-1, go to IDLE with dump_idx=0; otherwise dump_idx increments.
  - dump_start is ignored while in SCAN.
  - dump_data must stay stable while dump_ready=0, unless a write to that index lands; writes keep working during SCAN.
- Reset (rst=0 at a clock edge):
  - Clears all regs and all pend bits.
  - Forces the FSM to IDLE with dump_idx=0.
  - Overrides any write, issue or dump activity in that same cycle, including an abort mid-dump.

## Timing
- Read latency: 0 cycles (combinational). Write visible in regs on the next edge, and visible on rd1/rd2 in the same cycle through the bypass.
- Scoreboard: a set or clear takes effect on the edge. hazard reflects the registered pend state plus the current-cycle write.
- Dump throughput: 1 beat per cycle while dump_ready=1. A full dump with ready held high takes NREGS cycles from the first dump_valid.
- dump_start asserted in cycle t gives dump_valid=1 in cycle t+1.
- Reset values: rd1=rd2=0 (all registers zero), hazard=0, dump_valid=0, dump_busy=0, dump_idx=0, dump_data=0.

## Test plan
- Write and bypass: we=1, wa=5, wd=0xDEADBEEF, rs1=5 in the same cycle -> rd1=0xDEADBEEF that cycle. Next cycle, with we=0 -> rd1=0xDEADBEEF.
- Zero register: we=1, wa=0, wd=0x1234, rs2=0 -> rd2=0 that cycle and afterwards. iss_valid=1 with iss_rd=0 -> hazard stays 0 with rs1=0.
- Scoreboard:
  - Issue rd=7, then rs1=7 the next cycle -> hazard=1.
  - Writeback with we=1, wa=7 -> hazard=0 in the same cycle and rd1=wd.
  - Simultaneous iss_rd=7 and wa=7 -> pend[7] stays 1 afterwards.
- Dump backpressure:
  - Preload regs[i]=i*3, pulse dump_start, toggle dump_ready every other cycle -> beats idx 0..NREGS-1 with data i*3, none skipped or repeated.
  - dump_busy deasserts after idx NREGS-1 is accepted.
- Reset mid-operation: rst=0 during SCAN at idx=10 with pend[3]=1 and we=1 on that edge -> next cycle dump_valid=0, dump_idx=0, hazard=0, and every register reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with a hardwired zero register, write-to-read bypass,
// a pending-write scoreboard for hazard detection, and a valid/ready register dump stream.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  output logic            hazard,
  input  logic            dump_start,
  input  logic            dump_ready,
  output logic            dump_valid,
  output logic [AW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_busy
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] pend_next;
  logic             wr_en;
  logic             h1;
  logic             h2;

  assign wr_en = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wa] <= wd;
    end
  end

  // Clear first, then set, so a new producer on the same index supersedes the writeback.
  always_comb begin
    pend_next = pend;
    if (wr_en) pend_next[wa] = 1'b0;
    if (iss_valid && (iss_rd != '0)) pend_next[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) pend <= '0;
    else      pend <= pend_next;
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) rd1 = (we && (wa == rs1)) ? wd : regs[rs1];
    if (rs2 != '0) rd2 = (we && (wa == rs2)) ? wd : regs[rs2];
  end

  assign h1     = (rs1 != '0) && pend[rs1] && !(we && (wa == rs1));
  assign h2     = (rs2 != '0) && pend[rs2] && !(we && (wa == rs2));
  assign hazard = h1 || h2;

  assign dump_data = regs[dump_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      dump_idx   <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dump_start) begin
            state      <= SCAN;
            dump_idx   <= '0;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (dump_valid && dump_ready) begin
            if (dump_idx == AW'(NREGS - 1)) begin
              state      <= IDLE;
              dump_idx   <= '0;
              dump_valid <= 1'b0;
              dump_busy  <= 1'b0;
            end else begin
              dump_idx <= dump_idx + AW'(1);
            end
          end
        end
        default: begin
          state      <= IDLE;
          dump_idx   <= '0;
          dump_valid <= 1'b0;
          dump_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
